game_flow_ctrl: RTL and testbench
=================================

# game_flow_ctrl

Game-flow controller for the countdown timer. It takes the player's start, pause and level-select inputs and the timer's `timeout`, and produces the `timerReconfig`, `timerEnable` and `gameLevel` controls that drive the two-digit timer. It also tracks whether a round is running, won or lost. It sits directly upstream of the two-digit timer and also consumes that timer's `timeout`.

## Interface
Parameters:
- `HOLD_CYCLES`, default 50_000_000: number of cycles the WON/LOST result is held before returning to IDLE (1 s at 50 MHz). Legal range is ≥1.

Ports:
- `clk`  in  1  system clock. All logic is on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low. One clock; no other clock domains.
- `startPulse`  in  1  one-cycle start request (already debounced and synchronous).
- `pausePulse`  in  1  one-cycle pause/resume toggle request.
- `levelSel`  in  2  requested level: 01 easy (99 s), 10 medium (60 s), 11 hard (30 s), 00 invalid.
- `playerWin`  in  1  level-complete indication from game logic. Sampled only in RUN.
- `timeout`  in  1  countdown reached 00, from the timer.
- `timerReconfig`  out  1  one-cycle load of the timer initial value.
- `timerEnable`  out  1  timer counting enable.
- `gameLevel`  out  2  latched level presented to the timer.
- `gameActive`  out  1  high in RUN or PAUSE.
- `gamePaused`  out  1  high in PAUSE.
- `gameOver`  out  1  high in LOST.
- `gameWon`  out  1  high in WON.

## Operation
- Moore FSM with states IDLE, LOAD, RUN, PAUSE, LOST, WON. All outputs are decoded from registered state or registers; there are no combinational paths from input to output.
- Reset (`rst`=0): state IDLE, `gameLevel`=00, hold counter 0, all single-bit outputs 0.
- **IDLE**
  - `startPulse`=1 with `levelSel`≠00: latch `levelSel` into `gameLevel`, then go to LOAD.
  - `startPulse` with `levelSel`=00 is ignored.
- **LOAD**: `timerReconfig`=1 and `timerEnable`=0 for exactly one cycle. Unconditionally go to RUN.
- **RUN**: `timerEnable`=1 and `gameActive`=1. Priority order:
  - `playerWin` → WON.
  - else `timeout` → LOST.
  - else `pausePulse` → PAUSE.
- Simultaneous `playerWin` and `timeout` in RUN: WON (the player wins ties).
- **PAUSE**: `timerEnable`=0, `gameActive`=1, `gamePaused`=1. `pausePulse` → RUN. `playerWin`, `timeout` and `startPulse` are ignored.
- **LOST / WON**: `timerEnable`=0, and `gameOver` (or `gameWon`) is high. The hold counter increments every cycle; after `HOLD_CYCLES` cycles in the state, go to IDLE and clear the counter. `startPulse` and `pausePulse` are ignored during the hold.
- `gameLevel` holds its value through the round and the result hold, and changes only on an accepted start.
- `startPulse` in LOAD, RUN or PAUSE is ignored. There is no restart mid-round; only `rst` aborts a round.
- Hold counter width is clog2(`HOLD_CYCLES`+1). It must not wrap.

## Timing
- Accepted start sampled at edge N:
  - LOAD, `timerReconfig`=1 and the new `gameLevel` are visible after edge N (cycle N+1).
  - RUN with `timerEnable`=1 follows in cycle N+2.
- `gameLevel` is stable during the `timerReconfig` cycle, so the timer's level decode is valid at load.
- `timeout` or `playerWin` sampled at edge M in RUN: `timerEnable`=0 and the result flag is high from cycle M+1.
- `pausePulse` at edge P: `timerEnable` toggles from cycle P+1.
- Result state is entered at edge R: IDLE is entered at edge R+`HOLD_CYCLES`.
- Asserting `rst` in any state forces IDLE asynchronously. All outputs return to their reset values immediately.

## Configuration
- `GAME_PAUSE_EN` defined: PAUSE state and the `gamePaused` logic are built as described above.
- `GAME_PAUSE_EN` undefined:
  - PAUSE state is removed.
  - `pausePulse` port is kept for interface stability but ignored.
  - `gamePaused` is tied to 0.
  - RUN exits only on win or timeout.

## Structure
- Shared package `game_pkg`:
  - state encoding constants (3-bit): IDLE, LOAD, RUN, PAUSE, LOST, WON.
  - level constants: LEVEL_NONE=00, LEVEL_EASY=01, LEVEL_MED=10, LEVEL_HARD=11.
  - the default `HOLD_CYCLES` value.
- One sub-module, `result_hold_counter`:
  - inputs: `clk`, `rst`, `count_en`, `clear`.
  - output: `done` pulse when the count reaches `HOLD_CYCLES`.
  - `HOLD_CYCLES` is passed down as a parameter.

## Test plan
Benches run with `HOLD_CYCLES`=4.
- **Start, hard level**: `levelSel`=11, `startPulse` at edge 0 → cycle 1: `timerReconfig`=1, `gameLevel`=11, `timerEnable`=0. Cycle 2 onward: `timerEnable`=1, `gameActive`=1.
- **Invalid level**: `levelSel`=00, `startPulse` → state stays IDLE, all outputs 0, `gameLevel` stays 00.
- **Timeout hold**: RUN, `timeout` at edge M → cycles M+1..M+4: `gameOver`=1, `timerEnable`=0. IDLE at edge M+4. A `startPulse` at M+2 is ignored.
- **Win/timeout tie**: RUN, `playerWin`=`timeout`=1 in the same cycle → `gameWon`=1, `gameOver`=0.
- **Pause** (with `GAME_PAUSE_EN`): `pausePulse` in RUN → `timerEnable`=0 and `gamePaused`=1 next cycle. A `timeout` while paused is ignored. A second `pausePulse` → `timerEnable`=1. Without the macro, `pausePulse` has no effect.
- **Mid-round reset**: `rst`=0 during RUN → asynchronous IDLE, `gameLevel`=00, `timerEnable`=0 before the next clock edge.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the game-flow controller.
//   - state_e     : 3-bit FSM state encoding (IDLE, LOAD, RUN, PAUSE, LOST, WON)
//   - LEVEL_*     : 2-bit level codes presented to the two-digit timer
//   - HOLD_CYCLES_DEFAULT : result hold time, 1 s at 50 MHz
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_LOST  = 3'd4,
    ST_WON   = 3'd5
  } state_e;

  localparam logic [1:0] LEVEL_NONE = 2'b00;
  localparam logic [1:0] LEVEL_EASY = 2'b01;
  localparam logic [1:0] LEVEL_MED  = 2'b10;
  localparam logic [1:0] LEVEL_HARD = 2'b11;

  localparam int unsigned HOLD_CYCLES_DEFAULT = 32'd50_000_000;

endpackage : game_pkg

// File: rtl/game_flow_ctrl_result_hold_counter.sv
// result_hold_counter: counts cycles spent in a result state (WON/LOST).
//   clk      in  system clock
//   rst      in  asynchronous active-low reset
//   count_en in  high while the controller sits in a result state
//   clear    in  synchronous clear of the count
//   done     out high during the HOLD_CYCLES-th enabled cycle, so the
//                controller leaves the result state on that edge
// The counter saturates at HOLD_CYCLES and never wraps.
module result_hold_counter #(
  parameter int unsigned HOLD_CYCLES = 32'd4
) (
  input  logic clk,
  input  logic rst,
  input  logic count_en,
  input  logic clear,
  output logic done
);

  localparam int unsigned CW = $clog2(HOLD_CYCLES + 32'd1);
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 32'd1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(HOLD_CYCLES);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: cleared when idle or told to, saturating increment otherwise.
  always_comb begin
    cnt_d = cnt_q;
    if (clear || !count_en) begin
      cnt_d = '0;
    end else if (cnt_q < CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The count lags the cycle index by one, so the last hold cycle shows HOLD_CYCLES-1.
  assign done = count_en && (cnt_q == CNT_LAST);

endmodule : result_hold_counter

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: game-flow controller for the two-digit countdown timer.
//   clk           in  system clock, rising edge
//   rst           in  asynchronous active-low reset
//   startPulse    in  one-cycle start request
//   pausePulse    in  one-cycle pause/resume toggle (ignored without GAME_PAUSE_EN)
//   levelSel[1:0] in  requested level (00 invalid)
//   playerWin     in  level-complete indication, sampled only in RUN
//   timeout       in  timer reached 00
//   timerReconfig out one-cycle timer load (LOAD state)
//   timerEnable   out timer counting enable (RUN state)
//   gameLevel     out latched level, changes only on an accepted start
//   gameActive    out RUN or PAUSE
//   gamePaused    out PAUSE
//   gameOver      out LOST
//   gameWon       out WON
// Build option: define GAME_PAUSE_EN to include the PAUSE state.
// All outputs are flops loaded from the next state, so nothing is
// combinational from input to output.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       startPulse,
  input  logic       pausePulse,
  input  logic [1:0] levelSel,
  input  logic       playerWin,
  input  logic       timeout,
  output logic       timerReconfig,
  output logic       timerEnable,
  output logic [1:0] gameLevel,
  output logic       gameActive,
  output logic       gamePaused,
  output logic       gameOver,
  output logic       gameWon
);

  state_e     state_q;
  state_e     state_d;
  logic [1:0] level_q;
  logic [1:0] level_d;
  logic       reconfig_q;
  logic       enable_q;
  logic       active_q;
  logic       paused_q;
  logic       over_q;
  logic       won_q;
  logic       paused_d;
  logic       hold_en_s;
  logic       hold_done_s;

`ifndef GAME_PAUSE_EN
  logic       unused_pause_s;
  assign unused_pause_s = pausePulse;
`endif

  assign hold_en_s = (state_q == ST_LOST) || (state_q == ST_WON);

  result_hold_counter #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold (
    .clk      (clk),
    .rst      (rst),
    .count_en (hold_en_s),
    .clear    (hold_done_s),
    .done     (hold_done_s)
  );

  // Next-state and level-latch logic.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    case (state_q)
      ST_IDLE: begin
        if (startPulse && (levelSel != LEVEL_NONE)) begin
          level_d = levelSel;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // Win beats timeout when both arrive together.
        if (playerWin) begin
          state_d = ST_WON;
        end else if (timeout) begin
          state_d = ST_LOST;
`ifdef GAME_PAUSE_EN
        end else if (pausePulse) begin
          state_d = ST_PAUSE;
`endif
        end else begin
          state_d = ST_RUN;
        end
      end
`ifdef GAME_PAUSE_EN
      ST_PAUSE: begin
        if (pausePulse) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_PAUSE;
        end
      end
`endif
      ST_LOST, ST_WON: begin
        if (hold_done_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Paused flag decode; constant zero when the PAUSE state is not built.
  always_comb begin
`ifdef GAME_PAUSE_EN
    paused_d = (state_d == ST_PAUSE);
`else
    paused_d = 1'b0;
`endif
  end

  // State, level and registered output flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      level_q    <= LEVEL_NONE;
      reconfig_q <= 1'b0;
      enable_q   <= 1'b0;
      active_q   <= 1'b0;
      paused_q   <= 1'b0;
      over_q     <= 1'b0;
      won_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      reconfig_q <= (state_d == ST_LOAD);
      enable_q   <= (state_d == ST_RUN);
      active_q   <= (state_d == ST_RUN) || (state_d == ST_PAUSE);
      paused_q   <= paused_d;
      over_q     <= (state_d == ST_LOST);
      won_q      <= (state_d == ST_WON);
    end
  end

  assign timerReconfig = reconfig_q;
  assign timerEnable   = enable_q;
  assign gameLevel     = level_q;
  assign gameActive    = active_q;
  assign gamePaused    = paused_q;
  assign gameOver      = over_q;
  assign gameWon       = won_q;

endmodule : game_flow_ctrl

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed plus randomized stimulus for game_flow_ctrl,
// every output compared each cycle against a flag-based round model.
module tb_game_flow_ctrl;

  localparam int unsigned HOLD = 32'd4;
`ifdef GAME_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  localparam int R_NONE = 0;
  localparam int R_WON  = 1;
  localparam int R_LOST = 2;

  logic       clk;
  logic       rst;
  logic       startPulse;
  logic       pausePulse;
  logic [1:0] levelSel;
  logic       playerWin;
  logic       timeout;
  logic       timerReconfig;
  logic       timerEnable;
  logic [1:0] gameLevel;
  logic       gameActive;
  logic       gamePaused;
  logic       gameOver;
  logic       gameWon;

  int checks;
  int errors;

  // Round model: what the player would see, not how the FSM encodes it.
  logic [1:0] m_level;
  bit         m_loading;
  bit         m_active;
  bit         m_paused;
  int         m_result;
  int         m_held;

  game_flow_ctrl #(.HOLD_CYCLES(HOLD)) dut (
    .clk           (clk),
    .rst           (rst),
    .startPulse    (startPulse),
    .pausePulse    (pausePulse),
    .levelSel      (levelSel),
    .playerWin     (playerWin),
    .timeout       (timeout),
    .timerReconfig (timerReconfig),
    .timerEnable   (timerEnable),
    .gameLevel     (gameLevel),
    .gameActive    (gameActive),
    .gamePaused    (gamePaused),
    .gameOver      (gameOver),
    .gameWon       (gameWon)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_level   = 2'b00;
    m_loading = 1'b0;
    m_active  = 1'b0;
    m_paused  = 1'b0;
    m_result  = R_NONE;
    m_held    = 0;
  endtask

  // One clock edge of the game rules.
  task automatic model_edge(input bit s, input bit p, input logic [1:0] lv,
                            input bit w, input bit t);
    if (m_result != R_NONE) begin
      m_held = m_held + 1;
      if (m_held == int'(HOLD)) begin
        m_result = R_NONE;
        m_held   = 0;
      end
    end else if (m_loading) begin
      m_loading = 1'b0;
      m_active  = 1'b1;
      m_paused  = 1'b0;
    end else if (m_active) begin
      if (m_paused) begin
        if (p) m_paused = 1'b0;
      end else if (w) begin
        m_active = 1'b0; m_result = R_WON;  m_held = 0;
      end else if (t) begin
        m_active = 1'b0; m_result = R_LOST; m_held = 0;
      end else if (p && PAUSE_EN) begin
        m_paused = 1'b1;
      end
    end else if (s && lv != 2'b00) begin
      m_level   = lv;
      m_loading = 1'b1;
    end
  endtask

  function automatic logic [7:0] expected();
    return {m_loading, (m_active && !m_paused), m_active, m_paused,
            (m_result == R_LOST), (m_result == R_WON), m_level};
  endfunction

  task automatic check(input string tag);
    logic [7:0] obs;
    logic [7:0] exp;
    obs = {timerReconfig, timerEnable, gameActive, gamePaused,
           gameOver, gameWon, gameLevel};
    exp = expected();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b (rcfg,en,act,pau,over,won,lvl)",
             tag, obs, exp);
    end
  endtask

  // Drive inputs at the falling edge, clock them in, check at the next falling edge.
  task automatic cyc(input string tag, input bit s, input bit p,
                     input logic [1:0] lv, input bit w, input bit t);
    startPulse = s;
    pausePulse = p;
    levelSel   = lv;
    playerWin  = w;
    timeout    = t;
    @(posedge clk);
    model_edge(s, p, lv, w, t);
    @(negedge clk);
    check(tag);
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  // Asynchronous reset asserted mid-cycle, outputs checked before the next edge.
  task automatic async_reset(input string tag);
    rst = 1'b0;
    model_reset();
    #1;
    check(tag);
    @(negedge clk);
    check({tag, "_held"});
    rst = 1'b1;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b0;
    startPulse = 1'b0;
    pausePulse = 1'b0;
    levelSel   = 2'b00;
    playerWin  = 1'b0;
    timeout    = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_state");
    rst = 1'b1;
    idle_cycles("idle_after_reset", 2);

    // Hard-level start: LOAD with level 11, then RUN.
    cyc("start_hard_load", 1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
    cyc("start_hard_run", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    idle_cycles("run_steady", 2);
    // Timeout, start pulse at M+2 ignored, back to IDLE at M+4.
    cyc("timeout_m", 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    cyc("lost_m1", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    cyc("lost_m2_start_ignored", 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
    cyc("lost_m3", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    cyc("lost_m4_idle", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

    // Invalid level start is ignored.
    cyc("invalid_level", 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    idle_cycles("invalid_stay_idle", 2);

    // Easy start, start pulses during LOAD/RUN ignored, win/timeout tie goes to WON.
    cyc("start_easy", 1'b1, 1'b0, 2'b01, 1'b1, 1'b1);
    cyc("load_start_ignored", 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
    cyc("run_start_ignored", 1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
    cyc("tie_win", 1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
    idle_cycles("won_hold", 4);

    // Medium start then pause/resume; timeout and win while paused are ignored.
    cyc("start_med", 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
    cyc("med_run", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    cyc("pause_req", 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
    cyc("paused_timeout", 1'b0, 1'b0, 2'b00, 1'b0, (PAUSE_EN ? 1'b1 : 1'b0));
    cyc("paused_win", 1'b0, 1'b0, 2'b00, (PAUSE_EN ? 1'b1 : 1'b0), 1'b0);
    cyc("resume_req", 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
    idle_cycles("resumed_run", 2);

    // Mid-round reset.
    async_reset("midround_reset");
    idle_cycles("post_reset_idle", 2);

    // Randomized play.
    for (int i = 0; i < 600; i++) begin
      bit         s;
      bit         p;
      logic [1:0] lv;
      bit         w;
      bit         t;
      s  = ($urandom_range(0, 5) == 0);
      p  = ($urandom_range(0, 6) == 0);
      lv = 2'($urandom_range(0, 3));
      w  = ($urandom_range(0, 14) == 0);
      t  = ($urandom_range(0, 11) == 0);
      if (i == 300) begin
        async_reset("random_reset");
      end else begin
        cyc("random", s, p, lv, w, t);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_game_flow_ctrl
